// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared definitions for the multiplexed 7-segment scan controller.
//   GLYPH_TBL : active-high segment patterns (bit order gfedcba) for 0..F
//   state_e   : scan FSM states
//   clog2     : index width helper; never returns less than 1
package seg7_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // Entry n is the glyph for nibble value n (F listed first = MSB).
    localparam logic [15:0][6:0] GLYPH_TBL = {
        7'b1110001,  // F
        7'b1111001,  // E
        7'b1011110,  // d
        7'b0111001,  // C
        7'b1111100,  // b
        7'b1110111,  // A
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

    // Width needed to hold an index 0..n-1, with a floor of 1 bit so a
    // single-digit display still gets a legal vector.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_decode.sv
// seg7_decode -- combinational nibble to 7-segment glyph decoder.
//   nibble_i   : digit value 0..15
//   hex_mode_i : 1 = 10..15 render as A..F, 0 = render blank
//   glyph_o    : active-high segments, bit order gfedcba
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       hex_mode_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = GLYPH_TBL[nibble_i];
        if ((nibble_i > 4'd9) && !hex_mode_i) begin
            glyph_o = 7'b0000000;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl -- time-multiplexed driver for an N_DIGITS 7-segment display.
//   clk, rst        : clock, asynchronous active-high reset
//   display_en_i    : 1 = scanning, 0 = dark and halted
//   digits_i        : nibble i = value of digit i (digit 0 rightmost)
//   dp_i            : bit i = decimal point of digit i
//   hex_mode_i      : render 10..15 as A..F instead of blank
//   lz_suppress_i   : blank leading zeros
//   brightness_i    : on-time per slot in sixteenths (live, not shadowed)
//   seg_o, seg_dp_o : shared segment lines (gfedcba) and decimal point
//   digit_en_o      : one-hot (at most) digit enables
//   frame_start_o   : one-cycle pulse as digit 0 of a new frame begins
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 6,
    parameter int DIV_W       = 17,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit EN_ACT_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  display_en_i,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic                  hex_mode_i,
    input  logic                  lz_suppress_i,
    input  logic [3:0]            brightness_i,
    output logic [6:0]            seg_o,
    output logic                  seg_dp_o,
    output logic [N_DIGITS-1:0]   digit_en_o,
    output logic                  frame_start_o
);

    localparam int                  IDX_W    = clog2(N_DIGITS);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    // Inactive levels; XOR with these applies polarity to active-high data.
    localparam logic [6:0]          SEG_OFF  = {7{SEG_ACT_LOW}};
    localparam logic                DP_OFF   = SEG_ACT_LOW;
    localparam logic [N_DIGITS-1:0] EN_OFF   = {N_DIGITS{EN_ACT_LOW}};

    state_e                       state_q, state_d;
    logic [DIV_W-1:0]             div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [N_DIGITS-1:0][3:0]     dig_sh_q, dig_sh_d;
    logic [N_DIGITS-1:0]          dp_sh_q, dp_sh_d;
    logic                         hex_sh_q, hex_sh_d;
    logic                         lz_sh_q, lz_sh_d;
    logic                         frame_q, frame_d;
    logic [6:0]                   seg_q, seg_d;
    logic                         seg_dp_q, seg_dp_d;
    logic [N_DIGITS-1:0]          en_q, en_d;

    logic                         div_wrap, idx_wrap, capture, lit, blank;
    logic [3:0]                   phase;
    logic [N_DIGITS-1:0]          hi_zero;
    logic [6:0]                   glyph;

    assign div_wrap = &div_cnt_q;
    assign idx_wrap = div_wrap && (idx_q == IDX_LAST);
    // Shadow capture on entering SCAN and at each frame wrap; a falling
    // display_en in the same cycle suppresses it.
    assign capture  = display_en_i && ((state_q == ST_IDLE) || idx_wrap);
    assign phase    = div_cnt_q[DIV_W-1 -: 4];
    // Phase 0 stays dark so the previous digit's segments never ghost.
    assign lit      = (state_q == ST_SCAN) && display_en_i &&
                      (phase != 4'd0) && (phase <= brightness_i);

    // hi_zero[i] = shadow digits i..N_DIGITS-1 are all zero.
    always_comb begin
        logic run;
        run     = 1'b1;
        hi_zero = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run        = run && (dig_sh_q[i] == 4'd0);
            hi_zero[i] = run;
        end
    end

    assign blank = lz_sh_q && (idx_q != '0) && hi_zero[idx_q];

    seg7_decode u_decode (
        .nibble_i   (dig_sh_q[idx_q]),
        .hex_mode_i (hex_sh_q),
        .glyph_o    (glyph)
    );

    // Next state: scan counters, shadows, frame pulse.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        dig_sh_d  = dig_sh_q;
        dp_sh_d   = dp_sh_q;
        hex_sh_d  = hex_sh_q;
        lz_sh_d   = lz_sh_q;
        frame_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                idx_d     = '0;
                if (display_en_i) state_d = ST_SCAN;
            end
            default: begin
                if (!display_en_i) begin
                    state_d   = ST_IDLE;
                    div_cnt_d = '0;
                    idx_d     = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                    if (div_wrap) idx_d = idx_wrap ? '0 : idx_q + 1'b1;
                end
            end
        endcase

        if (capture) begin
            dig_sh_d = digits_i;
            dp_sh_d  = dp_i;
            hex_sh_d = hex_mode_i;
            lz_sh_d  = lz_suppress_i;
            frame_d  = 1'b1;
        end
    end

    // Output next state: one cycle behind the index/phase that produced it.
    always_comb begin
        seg_d    = SEG_OFF;
        seg_dp_d = DP_OFF;
        en_d     = EN_OFF;
        if (lit) begin
            en_d = EN_OFF ^ (N_DIGITS'(1) << idx_q);
            if (!blank) begin
                seg_d    = SEG_OFF ^ glyph;
                seg_dp_d = DP_OFF ^ dp_sh_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            idx_q     <= '0;
            dig_sh_q  <= '0;
            dp_sh_q   <= '0;
            hex_sh_q  <= 1'b0;
            lz_sh_q   <= 1'b0;
            frame_q   <= 1'b0;
            seg_q     <= SEG_OFF;
            seg_dp_q  <= DP_OFF;
            en_q      <= EN_OFF;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            dig_sh_q  <= dig_sh_d;
            dp_sh_q   <= dp_sh_d;
            hex_sh_q  <= hex_sh_d;
            lz_sh_q   <= lz_sh_d;
            frame_q   <= frame_d;
            seg_q     <= seg_d;
            seg_dp_q  <= seg_dp_d;
            en_q      <= en_d;
        end
    end

    assign seg_o         = seg_q;
    assign seg_dp_o      = seg_dp_q;
    assign digit_en_o    = en_q;
    assign frame_start_o = frame_q;

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 6: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter DIV_W, default 17: scan divider width; legal minimum 4; one digit slot lasts 2^DIV_W clk cycles.
REQ-003 Parameter SEG_ACT_LOW, default 1: 1 = seg/seg_dp driven active-low, 0 = active-high.
REQ-004 Parameter EN_ACT_LOW, default 1: 1 = digit_en driven active-low, 0 = active-high.
REQ-005 clk  input  1  clock; all logic is on the rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 display_en  input  1  1 = scan running, 0 = display dark and scan halted.
REQ-008 digits  input  4*N_DIGITS  nibble i = value of digit i; digit 0 = rightmost, least significant.
REQ-009 dp  input  N_DIGITS  bit i = decimal point of digit i.
REQ-010 hex_mode  input  1  1 = values 10..15 render as A,b,C,d,E,F; 0 = render blank.
REQ-011 lz_suppress  input  1  1 = blank leading zeros.
REQ-012 brightness  input  4  on-time per slot in sixteenths; 0 = dark.
REQ-013 seg  output  7  shared segments, bit order gfedcba.
REQ-014 seg_dp  output  1  shared decimal-point segment.
REQ-015 digit_en  output  N_DIGITS  digit enables, at most one active.
REQ-016 frame_start  output  1  one-cycle pulse when scanning of digit 0 begins.

Function
REQ-017 The FSM SHALL have two states: IDLE and SCAN; IDLE->SCAN when display_en=1, SCAN->IDLE when display_en=0; the transition takes effect on the next edge.
REQ-018 In IDLE, div_cnt, index and the phase SHALL be held at 0 and all outputs SHALL be inactive.
REQ-019 In SCAN, div_cnt SHALL increment each cycle and wrap from 2^DIV_W-1 to 0; the wrap SHALL advance index, and index SHALL wrap from N_DIGITS-1 to 0.
REQ-020 phase = div_cnt[DIV_W-1:DIV_W-4]; the slot digit SHALL be enabled only when phase != 0 and phase <= brightness; phase 0 is the anti-ghosting guard.
REQ-021 On the IDLE->SCAN edge and at every index wrap to 0, digits, dp, hex_mode and lz_suppress SHALL be captured into shadow registers; the display SHALL use only shadow values.
REQ-022 frame_start SHALL pulse for exactly the cycle following each shadow capture.
REQ-023 Leading-zero suppression SHALL blank digit i (segments and dp off) when i>0, lz_suppress=1, and shadow digits i..N_DIGITS-1 are all zero; digit 0 is never suppressed.
REQ-024 Glyphs (active-high): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-025 seg, seg_dp and digit_en SHALL be registered; each output SHALL reflect its index/phase with a latency of one cycle.
REQ-026 Polarity SHALL be applied at the output registers only; "inactive" means 1 when active-low and 0 when active-high.
REQ-027 brightness SHALL be sampled live, not shadowed; a change SHALL take effect from the next cycle.
REQ-028 When display_en and the index wrap occur in the same cycle that display_en falls, IDLE SHALL win: there is no capture and no frame_start.

Reset
REQ-029 During rst: state = IDLE; div_cnt, index, shadows and frame_start = 0; seg, seg_dp and digit_en are inactive.
REQ-030 Assertion of rst mid-scan SHALL force reset values immediately; after release, scanning restarts at digit 0 with a fresh capture.

Structure
REQ-031 Package seg7_pkg SHALL hold the glyph constants, the FSM state enum, and an index-width function clog2(N_DIGITS) with a minimum value of 1.
REQ-032 Sub-module seg7_decode SHALL be a combinational nibble+hex_mode -> 7-bit active-high glyph decoder, instantiated once.

Verification (use N_DIGITS=6, DIV_W=6: slot = 64 cycles, one phase = 4 cycles)
REQ-033 Bench SHALL cover: reset, then display_en=1, brightness=15, digits=0x123456 -> digit_en (active-low) walks 111110..011111 in 64-cycle slots; the slot for digit 0 shows 1111101 active-high ("6") in phases 1..15; all enables are off for the first 4 cycles of each slot; frame_start pulses every 384 cycles.
REQ-034 Bench SHALL cover: brightness=4 -> each digit is enabled for exactly 16 of 64 cycles; brightness=0 -> digit_en is never active.
REQ-035 Bench SHALL cover: digits=0x000070, lz_suppress=1 -> digits 5..2 are blank, digit 1 shows "7", digit 0 shows "0"; with lz_suppress=0, digit 5 shows "0".
REQ-036 Bench SHALL cover: digit 0 = 0xB with hex_mode=0 -> blank segments; with hex_mode=1 -> 1111100; dp=000001 -> seg_dp active only in the digit 0 slot.
REQ-037 Bench SHALL cover: change digits mid-frame -> displayed values are unchanged until after the next frame_start.
REQ-038 Bench SHALL cover: rst asserted in slot 3, and separately display_en dropped in slot 3 -> outputs go inactive; on resume, the first enabled digit is digit 0 with a new frame_start.
